iter_alu_exec: RTL and testbench
================================

// Module: iter_alu_exec
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit alu_control code from the control-unit decoder plus two operands.
//  Arithmetic/logic ops complete in one cycle; shift/rotate ops run iteratively (1 bit per cycle) to save area.
//  Produces a registered result and NZCV flags with a start/busy/done handshake for the multi-cycle datapath.
// PARAMETERS
//  WIDTH    32  operand/result width in bits
//  SHAMT_W  5   shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk          in   1        system clock, all state updates on rising edge
//  rst          in   1        synchronous reset, active-high
//  start        in   1        request: sample alu_control/a/b/shamt this edge (accepted only when not busy)
//  alu_control  in   4        operation code (table below)
//  a            in   WIDTH    operand A (Rn)
//  b            in   WIDTH    operand B (Rm / immediate / value to shift)
//  shamt        in   SHAMT_W  shift amount, used by shift codes only
//  busy         out  1        high while a shift is in progress; start ignored
//  done         out  1        one-cycle pulse: result/flags valid from this cycle on
//  result       out  WIDTH    registered result, held until next completed op
//  flags        out  4        registered {N,Z,C,V}, held until next completed op
// BEHAVIOUR
//  Clock clk, reset rst: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, busy=0, done=0, result=0, flags=4'b0000. Reset mid-shift aborts the op; no done issued.
//  Op codes: 0000 ADD a+b | 0001 SUB a-b | 0010 AND | 0011 ORR | 0100 EOR | 0101 MOV (b)
//            0110 BIC a&~b | 1000 LSL b | 1001 LSR b | 1010 ASR b | 1011 ROR b (shift by shamt)
//            any other code: result=0, flags=0100 (undefined -> zero, no fault).
//  FSM states: IDLE, SHIFT.
//   IDLE & start & non-shift code: edge E0 registers result/flags, done=1 for cycle after E0; stay IDLE.
//   IDLE & start & shift code: E0 loads shreg=b, cnt=shamt, carry=0, go SHIFT, busy=1.
//   SHIFT & cnt!=0: each edge shift shreg 1 bit, carry=bit shifted out (ROR: bit rotated), cnt-=1.
//   SHIFT & cnt==0: edge registers result=shreg, flags, done=1 next cycle, busy=0, go IDLE.
//  Latency: non-shift = 1 cycle; shift by n = n+1 cycles (shamt=0 -> result=b, C=0, latency 1).
//  Back-to-back: start accepted in the same cycle done is high (state already IDLE).
//  start while busy: ignored entirely, inputs not sampled, no queued request.
//  Inputs need only be stable at the accepting edge; a/b/shamt/alu_control may change during SHIFT.
//  Flags: N=result[WIDTH-1]; Z=(result==0).
//   ADD: C=carry out of bit WIDTH-1; V=signed overflow (a,b same sign, result differs).
//   SUB: computed as a+~b+1; C=carry out (1 = no borrow, a>=b unsigned); V=signed overflow.
//   Logic/MOV/BIC: C=0, V=0. Shifts: C=last bit shifted out (0 if shamt=0), V=0.
//  ASR replicates sign bit; LSR/LSL fill zero; ROR rotates right.
//  done is never high two consecutive cycles except for back-to-back single-cycle ops.
// TESTING
//  1 ADD a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, flags 1001, done 1 cycle after start.
//  2 SUB a=5 b=5 -> 0x00000000, flags 0110; SUB a=0 b=1 -> 0xFFFFFFFF, flags 1000.
//  3 LSL b=0x80000001 shamt=1 -> 0x00000002, flags 0010, busy 1 cycle, done 2 cycles after start.
//  4 ASR b=0x80000000 shamt=31 -> 0xFFFFFFFF, flags 1010 (C=last bit out=0 -> 1000), latency 32;
//    start pulsed with ADD while busy -> ignored, result still ASR value.
//  5 ROR b=0x00000001 shamt=1 -> 0x80000000, flags 1010; then ADD issued in done cycle completes next cycle.
//  6 rst asserted mid LSR (shamt=20, cycle 7) -> next cycle busy=0 done=0 result=0 flags=0; new op correct.
```

Note on test 4: the expected flags are 1000. The last bit shifted out of 0x80000000 on the 31st ASR step is bit 30, which is 0, so C=0.

Source files
------------

// File: rtl/iter_alu_exec.sv
// Execute-stage ALU: one-cycle arithmetic/logic ops and a 1-bit-per-cycle shifter,
// with registered result/NZCV flags and a start/busy/done handshake.
module iter_alu_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_MOV = 4'b0101;
    localparam logic [3:0] OP_BIC = 4'b0110;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    logic [0:0]         state;
    logic [WIDTH-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         sh_op;

    logic               is_shift;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   op_res;
    logic               op_c;
    logic               op_v;
    logic [WIDTH-1:0]   step_val;
    logic               step_c;

    assign is_shift = (alu_control[3:2] == 2'b10);
    assign busy     = (state == S_SHIFT);

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1 so C means "no borrow".
    always_comb begin
        sum    = '0;
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (alu_control)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                op_res = sum[WIDTH-1:0];
                op_c   = sum[WIDTH];
                op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (op_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  op_res = a & b;
            OP_ORR:  op_res = a | b;
            OP_EOR:  op_res = a ^ b;
            OP_MOV:  op_res = b;
            OP_BIC:  op_res = a & ~b;
            default: op_res = '0;
        endcase
    end

    // One shift step on the held operand; carry is the bit leaving the register.
    always_comb begin
        step_val = shreg;
        step_c   = 1'b0;
        case (sh_op)
            SH_LSL: begin
                step_val = {shreg[WIDTH-2:0], 1'b0};
                step_c   = shreg[WIDTH-1];
            end
            SH_LSR: begin
                step_val = {1'b0, shreg[WIDTH-1:1]};
                step_c   = shreg[0];
            end
            SH_ASR: begin
                step_val = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
                step_c   = shreg[0];
            end
            SH_ROR: begin
                step_val = {shreg[0], shreg[WIDTH-1:1]};
                step_c   = shreg[0];
            end
            default: begin
                step_val = shreg;
                step_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            result <= '0;
            flags  <= 4'b0000;
            shreg  <= '0;
            cnt    <= '0;
            sh_op  <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift && (shamt != '0)) begin
                            shreg <= b;
                            cnt   <= shamt;
                            sh_op <= alu_control[1:0];
                            state <= S_SHIFT;
                        end else if (is_shift) begin
                            // Zero-length shift completes immediately with C=0.
                            result <= b;
                            flags  <= {b[WIDTH-1], (b == '0), 1'b0, 1'b0};
                            done   <= 1'b1;
                        end else begin
                            result <= op_res;
                            flags  <= {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
                            done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg <= step_val;
                    cnt   <= cnt - SHAMT_W'(1);
                    // Last step retires in the same edge, giving n+1 cycle latency.
                    if (cnt == SHAMT_W'(1)) begin
                        result <= step_val;
                        flags  <= {step_val[WIDTH-1], (step_val == '0), step_c, 1'b0};
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu_exec.sv
// Randomized self-checking bench for iter_alu_exec against an arithmetic reference model.
module tb_iter_alu_exec;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    iter_alu_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] sh, output logic [31:0] r, output logic [3:0] f);
        longint s;
        logic [63:0] w;
        logic c, v;
        int n;
        n = int'(sh);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (code)
            4'h0: begin
                r = x + y;
                w = {32'b0, x} + {32'b0, y};
                c = w[32];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h1: begin
                r = x - y;
                c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: r = y;
            4'h6: r = x & ~y;
            4'h8: begin
                w = {32'b0, y} << n;
                r = w[31:0];
                c = w[32];
            end
            4'h9: begin
                r = y >> n;
                c = (n != 0) ? y[n-1] : 1'b0;
            end
            4'hA: begin
                r = 32'($signed(y) >>> n);
                c = (n != 0) ? y[n-1] : 1'b0;
            end
            4'hB: begin
                r = (n == 0) ? y : ((y >> n) | (y << (32 - n)));
                c = (n != 0) && r[31];
            end
            default: r = '0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] oa,
                          input logic [31:0] ob, input logic [4:0] sh, input bit noise);
        logic [31:0] er;
        logic [3:0]  ef;
        int lat, elat;
        model(code, oa, ob, sh, er, ef);
        elat = (code[3:2] == 2'b10 && sh != 5'd0) ? int'(sh) + 1 : 1;
        start = 1'b1; alu_control = code; a = oa; b = ob; shamt = sh;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) chk({tag, ".busy"}, 64'(busy), 64'(elat > 1));
            if (!done && busy) begin
                a = $urandom; b = $urandom; shamt = 5'($urandom); alu_control = 4'($urandom);
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    alu_control = 4'h0;
                end
            end
        end while (!done && lat < 100);
        start = 1'b0;
        chk({tag, ".lat"}, 64'(lat), 64'(elat));
        chk({tag, ".res"}, 64'(result), 64'(er));
        chk({tag, ".flg"}, 64'(flags), 64'(ef));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0; shamt = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.res",  64'(result), 64'(0));
        chk("rst.flg",  64'(flags), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ovf", 4'h0, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0);
        chk("add_ovf.exp", 64'({result, flags}), 64'({32'h80000000, 4'b1001}));
        @(negedge clk);
        chk("done.pulse", 64'(done), 64'(0));
        run_op("sub_eq", 4'h1, 32'd5, 32'd5, 5'd0, 1'b0);
        chk("sub_eq.exp", 64'({result, flags}), 64'({32'h0, 4'b0110}));
        run_op("sub_brw", 4'h1, 32'd0, 32'd1, 5'd0, 1'b0);
        chk("sub_brw.exp", 64'({result, flags}), 64'({32'hFFFFFFFF, 4'b1000}));
        run_op("lsl1", 4'h8, 32'h0, 32'h80000001, 5'd1, 1'b0);
        chk("lsl1.exp", 64'({result, flags}), 64'({32'h2, 4'b0010}));
        run_op("asr31", 4'hA, 32'h0, 32'h80000000, 5'd31, 1'b1);
        chk("asr31.exp", 64'({result, flags}), 64'({32'hFFFFFFFF, 4'b1000}));
        run_op("ror1", 4'hB, 32'h0, 32'h1, 5'd1, 1'b0);
        chk("ror1.exp", 64'({result, flags}), 64'({32'h80000000, 4'b1010}));
        run_op("b2b_add", 4'h0, 32'd3, 32'd4, 5'd0, 1'b0);
        run_op("undef", 4'hE, 32'h1234, 32'h5678, 5'd3, 1'b0);
        run_op("lsr0", 4'h9, 32'h0, 32'h80000000, 5'd0, 1'b0);

        // Reset during a long LSR: the op is dropped without done.
        @(negedge clk);
        start = 1'b1; alu_control = 4'h9; b = 32'hDEADBEEF; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.busy", 64'(busy), 64'(0));
        chk("midrst.done", 64'(done), 64'(0));
        chk("midrst.res",  64'(result), 64'(0));
        chk("midrst.flg",  64'(flags), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst", 4'h9, 32'h0, 32'hF0000000, 5'd4, 1'b0);

        for (int i = 0; i < 80; i++) begin
            run_op("rand", 4'($urandom), pick(), pick(), 5'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
        chk("idle.done", 64'(done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
